// File: rtl/decimating_averager.sv
// decimating_averager: averages non-overlapping blocks of 2**LOG2_DECIM samples
// and queues the results in a small valid/ready output FIFO.
`default_nettype none

module decimating_averager #(
   parameter int WIDTH      = 16,
   parameter int LOG2_DECIM = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic [WIDTH-1:0]              in,
   output logic [WIDTH-1:0]              out,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overflow
);

   localparam int ACC_W = WIDTH + LOG2_DECIM;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic signed [ACC_W-1:0]  acc;
   logic [LOG2_DECIM-1:0]    cnt;
   logic signed [ACC_W-1:0]  in_ext;
   logic signed [ACC_W-1:0]  sum;
   logic [WIDTH-1:0]         result;
   logic                     block_done;

   logic [WIDTH-1:0]         mem [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr;
   logic [PTR_W-1:0]         rd_ptr;
   logic                     full;
   logic                     push;
   logic                     pop;
   logic                     drop;

   assign in_ext     = {{LOG2_DECIM{in[WIDTH-1]}}, in};
   assign sum        = acc + in_ext;
   // Taking the upper WIDTH bits is an arithmetic shift right (floor toward -inf).
   assign result     = sum[ACC_W-1:LOG2_DECIM];
   assign block_done = en && (&cnt);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc <= '0;
         cnt <= '0;
      end else if (block_done) begin
         acc <= '0;
         cnt <= '0;
      end else if (en) begin
         acc <= sum;
         cnt <= cnt + LOG2_DECIM'(1);
      end
   end

   assign full      = (level == LVL_W'(FIFO_DEPTH));
   assign out_valid = (level != '0);
   assign pop       = out_valid && out_ready;
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign push      = block_done && (!full || pop);
   assign drop      = block_done && full && !pop;
   assign out       = out_valid ? mem[rd_ptr] : '0;

   // Storage needs no reset: the pointers and level define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= result;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            level <= level + LVL_W'(1);
         end else if (pop && !push) begin
            level <= level - LVL_W'(1);
         end
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_decimating_averager.sv
// Directed self-checking bench for decimating_averager (WIDTH=16, DECIM=8, depth 4).
`default_nettype none

module tb_decimating_averager;

   logic              clk;
   logic              rst;
   logic              en;
   logic [15:0]       in;
   logic [15:0]       out;
   logic              out_valid;
   logic              out_ready;
   logic [2:0]        level;
   logic              overflow;

   int n_checks = 0;
   int n_fails  = 0;

   decimating_averager #(
      .WIDTH(16), .LOG2_DECIM(3), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .in(in), .out(out),
      .out_valid(out_valid), .out_ready(out_ready), .level(level),
      .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Stimulus helpers; all drive changes happen 1 time unit after a rising edge.
   task automatic send(input logic [15:0] v);
      en = 1'b1;
      in = v;
      @(posedge clk); #1;
      en = 1'b0;
      in = 16'h5A5A;
   endtask

   task automatic send_block(input logic [15:0] v);
      for (int i = 0; i < 8; i++) send(v);
   endtask

   task automatic pop_one();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      #2;
      rst = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; en = 1'b0; in = '0; out_ready = 1'b0;
      #3;
      n_checks++;
      if (out_valid !== 1'b0 || level !== 3'd0 || out !== 16'd0 || overflow !== 1'b0) begin
         n_fails++;
         $display("FAIL reset_state: valid=%b level=%0d out=%h ovf=%b, required 0 0 0000 0",
                  out_valid, level, out, overflow);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      send_block(16'd7);
      for (int i = 0; i < 5; i++) send(16'd500);
      n_checks++;
      if (level !== 3'd1) begin
         n_fails++;
         $display("FAIL reset_pre_level: level=%0d, required 1", level);
      end
      rst = 1'b0;
      #2;
      n_checks++;
      if (out_valid !== 1'b0 || level !== 3'd0 || out !== 16'd0) begin
         n_fails++;
         $display("FAIL reset_async: valid=%b level=%0d out=%h, required 0 0 0000",
                  out_valid, level, out);
      end
      rst = 1'b1;
      #1;
      send_block(16'd100);
      n_checks++;
      if (out_valid !== 1'b1 || out !== 16'd100 || level !== 3'd1) begin
         n_fails++;
         $display("FAIL reset_clean_block: valid=%b out=%0d level=%0d, required 1 100 1",
                  out_valid, $signed(out), level);
      end
      pop_one();
   endtask

   task automatic test_constant();
      for (int i = 0; i < 7; i++) send(16'd1000);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fails++;
         $display("FAIL const_early: valid=%b after 7 samples, required 0", out_valid);
      end
      send(16'd1000);
      n_checks++;
      if (out_valid !== 1'b1 || out !== 16'd1000 || level !== 3'd1) begin
         n_fails++;
         $display("FAIL const_avg: valid=%b out=%0d level=%0d, required 1 1000 1",
                  out_valid, $signed(out), level);
      end
      pop_one();
      n_checks++;
      if (out_valid !== 1'b0 || level !== 3'd0 || out !== 16'd0) begin
         n_fails++;
         $display("FAIL const_pop: valid=%b level=%0d out=%h, required 0 0 0000",
                  out_valid, level, out);
      end
   endtask

   task automatic test_floor_extremes();
      for (int i = -4; i <= 3; i++) send(16'(i));
      n_checks++;
      if (out !== 16'hFFFF) begin
         n_fails++;
         $display("FAIL floor_neg: out=%0d, required -1", $signed(out));
      end
      pop_one();
      send_block(16'h7FFF);
      n_checks++;
      if (out !== 16'h7FFF) begin
         n_fails++;
         $display("FAIL max_pos: out=%0d, required 32767", $signed(out));
      end
      pop_one();
      send_block(16'h8000);
      n_checks++;
      if (out !== 16'h8000 || overflow !== 1'b0) begin
         n_fails++;
         $display("FAIL max_neg: out=%0d ovf=%b, required -32768 0", $signed(out), overflow);
      end
      pop_one();
   endtask

   task automatic test_en_gaps();
      out_ready = 1'b1;
      for (int s = 1; s <= 16; s++) begin
         send(16'hFF38);
         if (s == 7 || s == 15) begin
            n_checks++;
            if (out_valid !== 1'b0) begin
               n_fails++;
               $display("FAIL gap_early strobe %0d: valid=%b, required 0", s, out_valid);
            end
         end
         if (s == 8 || s == 16) begin
            n_checks++;
            if (out_valid !== 1'b1 || out !== 16'hFF38) begin
               n_fails++;
               $display("FAIL gap_avg strobe %0d: valid=%b out=%0d, required 1 -200",
                        s, out_valid, $signed(out));
            end
         end
         in = 16'd7777;
         @(posedge clk); #1;
         @(posedge clk); #1;
      end
      n_checks++;
      if (level !== 3'd0) begin
         n_fails++;
         $display("FAIL gap_drain: level=%0d, required 0", level);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_overflow();
      pulse_reset();
      for (int b = 1; b <= 4; b++) send_block(16'(10 * b));
      n_checks++;
      if (level !== 3'd4 || overflow !== 1'b0) begin
         n_fails++;
         $display("FAIL ovf_fill: level=%0d ovf=%b, required 4 0", level, overflow);
      end
      send_block(16'd50);
      n_checks++;
      if (level !== 3'd4 || overflow !== 1'b1) begin
         n_fails++;
         $display("FAIL ovf_drop: level=%0d ovf=%b, required 4 1", level, overflow);
      end
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out !== 16'(10 * i)) begin
            n_fails++;
            $display("FAIL ovf_order %0d: valid=%b out=%0d, required 1 %0d",
                     i, out_valid, $signed(out), 10 * i);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      n_checks++;
      if (level !== 3'd0 || out_valid !== 1'b0 || overflow !== 1'b1) begin
         n_fails++;
         $display("FAIL ovf_sticky: level=%0d valid=%b ovf=%b, required 0 0 1",
                  level, out_valid, overflow);
      end
   endtask

   task automatic test_back_to_back();
      pulse_reset();
      for (int b = 1; b <= 4; b++) send_block(16'(b));
      for (int i = 0; i < 7; i++) send(16'd5);
      out_ready = 1'b1;
      send(16'd5);
      out_ready = 1'b0;
      n_checks++;
      if (level !== 3'd4 || overflow !== 1'b0 || out !== 16'd2) begin
         n_fails++;
         $display("FAIL simul_pushpop: level=%0d ovf=%b out=%0d, required 4 0 2",
                  level, overflow, $signed(out));
      end
      out_ready = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         n_checks++;
         if (out !== 16'(i)) begin
            n_fails++;
            $display("FAIL simul_order: out=%0d, required %0d", $signed(out), i);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      n_checks++;
      if (level !== 3'd0 || overflow !== 1'b0) begin
         n_fails++;
         $display("FAIL simul_drain: level=%0d ovf=%b, required 0 0", level, overflow);
      end
   endtask

   initial begin
      test_reset();
      test_constant();
      test_floor_extremes();
      test_en_gaps();
      test_overflow();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

`default_nettype wire
